// File: rtl/matmul_seq_pkg.sv
// Shared encodings for the SPI matmul command sequencer: opcodes, FSM states,
// error codes and the status-word magic byte.
package matmul_seq_pkg;

    typedef enum logic [7:0] {
        OP_LOAD_A  = 8'h01,
        OP_LOAD_B  = 8'h02,
        OP_COMPUTE = 8'h03,
        OP_READ_C  = 8'h04,
        OP_STATUS  = 8'h05
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMP_GO,
        ST_COMP_WAIT,
        ST_SEND_GO,
        ST_SEND_WAIT,
        ST_STAT_TX
    } state_e;

    localparam logic [7:0] ERR_NONE         = 8'h00;
    localparam logic [7:0] ERR_BAD_OP       = 8'h01;
    localparam logic [7:0] ERR_BAD_DIM      = 8'h02;
    localparam logic [7:0] ERR_DIM_MISMATCH = 8'h03;
    localparam logic [7:0] ERR_NOT_READY    = 8'h04;
    localparam logic [7:0] ERR_TIMEOUT      = 8'h05;

    localparam logic [7:0] STATUS_MAGIC = 8'hA5;

endpackage

// File: rtl/seq_watchdog.sv
// Payload watchdog: counts enabled cycles since the last clear and saturates
// at TIMEOUT, holding expired high once reached.
module seq_watchdog #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && cnt_q != LIMIT)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/spi_matmul_sequencer.sv
// Command sequencer between the SPI slave and the matmul datapath: decodes
// headers, streams operands, launches compute/readback and answers STATUS.
module spi_matmul_sequencer
    import matmul_seq_pkg::*;
#(
    parameter int MAX_M   = 10,
    parameter int MAX_N   = 10,
    parameter int TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        ld_we,
    output logic        ld_sel,
    output logic [15:0] ld_addr,
    output logic [31:0] ld_data,
    output logic [7:0]  dim_m,
    output logic [7:0]  dim_k,
    output logic [7:0]  dim_n,
    output logic        comp_start,
    input  logic        comp_done,
    output logic        send_start,
    output logic [15:0] send_size,
    input  logic        send_done,
    output logic        busy,
    output logic [7:0]  err_code
);

    localparam logic [7:0] MAX_M8 = 8'(MAX_M);
    localparam logic [7:0] MAX_N8 = 8'(MAX_N);

    state_e      state_q, state_d;
    logic [7:0]  dim_m_q, dim_m_d, dim_k_q, dim_k_d, dim_n_q, dim_n_d;
    logic [7:0]  b_rows_q, b_rows_d;
    logic        sel_q, sel_d;
    logic [15:0] idx_q, idx_d, total_q, total_d;
    logic        a_valid_q, a_valid_d, b_valid_q, b_valid_d, c_valid_q, c_valid_d;
    logic [7:0]  err_q, err_d;
    logic        ld_we_q, ld_we_d;
    logic [15:0] ld_addr_q, ld_addr_d;
    logic [31:0] ld_data_q, ld_data_d;

    logic       rx_hs;
    logic       wd_expired;
    logic [7:0] hdr_op, hdr_rows, hdr_cols;
    logic       hdr_bad_dim;

    assign hdr_op      = rx_data[31:24];
    assign hdr_rows    = rx_data[23:16];
    assign hdr_cols    = rx_data[15:8];
    assign hdr_bad_dim = (hdr_rows == 8'd0) || (hdr_rows > MAX_M8) ||
                         (hdr_cols == 8'd0) || (hdr_cols > MAX_N8);

    // Gated with rst_n so every output reads 0 while reset is held.
    assign rx_ready = rst_n && (state_q == ST_IDLE || state_q == ST_LOAD);
    assign rx_hs    = rx_valid && rx_ready;

    seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (rx_hs || state_q != ST_LOAD),
        .enable  (state_q == ST_LOAD),
        .expired (wd_expired)
    );

    always_comb begin
        state_d   = state_q;
        dim_m_d   = dim_m_q;
        dim_k_d   = dim_k_q;
        dim_n_d   = dim_n_q;
        b_rows_d  = b_rows_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        total_d   = total_q;
        a_valid_d = a_valid_q;
        b_valid_d = b_valid_q;
        c_valid_d = c_valid_q;
        err_d     = err_q;
        ld_we_d   = 1'b0;
        ld_addr_d = ld_addr_q;
        ld_data_d = ld_data_q;

        case (state_q)
            ST_IDLE: if (rx_hs) begin
                case (hdr_op)
                    OP_LOAD_A, OP_LOAD_B: begin
                        if (hdr_bad_dim) begin
                            err_d = ERR_BAD_DIM;
                        end else begin
                            sel_d   = (hdr_op == OP_LOAD_B);
                            idx_d   = '0;
                            total_d = 16'(hdr_rows) * 16'(hdr_cols);
                            state_d = ST_LOAD;
                            if (hdr_op == OP_LOAD_B) begin
                                b_rows_d  = hdr_rows;
                                dim_n_d   = hdr_cols;
                                b_valid_d = 1'b0;
                            end else begin
                                dim_m_d   = hdr_rows;
                                dim_k_d   = hdr_cols;
                                a_valid_d = 1'b0;
                            end
                        end
                    end
                    OP_COMPUTE: begin
                        if (!(a_valid_q && b_valid_q)) err_d   = ERR_NOT_READY;
                        else if (dim_k_q != b_rows_q)  err_d   = ERR_DIM_MISMATCH;
                        else                           state_d = ST_COMP_GO;
                    end
                    OP_READ_C: begin
                        if (!c_valid_q) err_d   = ERR_NOT_READY;
                        else            state_d = ST_SEND_GO;
                    end
                    OP_STATUS: state_d = ST_STAT_TX;
                    default:   err_d   = ERR_BAD_OP;
                endcase
            end
            ST_LOAD: begin
                if (rx_hs) begin
                    ld_we_d   = 1'b1;
                    ld_addr_d = idx_q;
                    ld_data_d = rx_data;
                    idx_d     = idx_q + 16'd1;
                    if (idx_q == total_q - 16'd1) begin
                        if (sel_q) b_valid_d = 1'b1;
                        else       a_valid_d = 1'b1;
                        c_valid_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end else if (wd_expired) begin
                    if (sel_q) b_valid_d = 1'b0;
                    else       a_valid_d = 1'b0;
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_IDLE;
                end
            end
            ST_COMP_GO:   state_d = ST_COMP_WAIT;
            ST_COMP_WAIT: if (comp_done) begin
                c_valid_d = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_SEND_GO:   state_d = ST_SEND_WAIT;
            ST_SEND_WAIT: if (send_done) state_d = ST_IDLE;
            ST_STAT_TX:   if (tx_ready) begin
                err_d   = ERR_NONE;
                state_d = ST_IDLE;
            end
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            dim_m_q   <= '0;
            dim_k_q   <= '0;
            dim_n_q   <= '0;
            b_rows_q  <= '0;
            sel_q     <= 1'b0;
            idx_q     <= '0;
            total_q   <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            c_valid_q <= 1'b0;
            err_q     <= ERR_NONE;
            ld_we_q   <= 1'b0;
            ld_addr_q <= '0;
            ld_data_q <= '0;
        end else begin
            state_q   <= state_d;
            dim_m_q   <= dim_m_d;
            dim_k_q   <= dim_k_d;
            dim_n_q   <= dim_n_d;
            b_rows_q  <= b_rows_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            total_q   <= total_d;
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
            c_valid_q <= c_valid_d;
            err_q     <= err_d;
            ld_we_q   <= ld_we_d;
            ld_addr_q <= ld_addr_d;
            ld_data_q <= ld_data_d;
        end
    end

    assign tx_valid   = (state_q == ST_STAT_TX);
    assign tx_data    = tx_valid ? {STATUS_MAGIC, err_q, 5'b0, c_valid_q, b_valid_q, a_valid_q, 8'h00}
                                 : 32'h0;
    assign ld_we      = ld_we_q;
    assign ld_sel     = sel_q;
    assign ld_addr    = ld_addr_q;
    assign ld_data    = ld_data_q;
    assign dim_m      = dim_m_q;
    assign dim_k      = dim_k_q;
    assign dim_n      = dim_n_q;
    assign comp_start = (state_q == ST_COMP_GO);
    assign send_start = (state_q == ST_SEND_GO);
    assign send_size  = 16'(dim_m_q) * 16'(dim_n_q);
    assign busy       = (state_q != ST_IDLE);
    assign err_code   = err_q;

endmodule
